// File: rtl/dmt_pkg.sv
// rtl/dmt_pkg.sv - shared DMT constants and cyclic-prefix read FSM encoding
package dmt_pkg;

    localparam int N_FFT          = 128;
    localparam int IDX_W          = 7;
    localparam int DATA_W_DEFAULT = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_t;

endpackage

// File: rtl/cp_ram.sv
// rtl/cp_ram.sv - simple dual-port 256 x DATA_W symbol buffer, address {bank, idx}, 1-cycle read
module cp_ram
    import dmt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              SYS_CLK,
    input  logic              wr_en,
    input  logic [IDX_W:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:2*N_FFT-1];

    // write port: one sample per cycle from the input side
    always_ff @(posedge SYS_CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // read port: registered, data appears the cycle after the address
    always_ff @(posedge SYS_CLK) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cp_insert.sv
// rtl/cp_insert.sv - cyclic-prefix inserter with ping-pong buffering; CP_INSERT_IDX_CHECK_EN enables index checking
module cp_insert
    import dmt_pkg::*;
#(
    parameter int CP_LEN = 32,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] S_DATA_RE_IN,
    input  logic [IDX_W-1:0]  S_DATA_IDX_IN,
    input  logic              S_DATA_VALID,
    input  logic              S_DATA_LAST,
    output logic [DATA_W-1:0] M_DATA_OUT,
    output logic              M_DATA_VALID,
    input  logic              M_DATA_READY,
    output logic              M_DATA_FIRST,
    output logic              M_DATA_LAST,
    output logic              ERR_LEN,
    output logic              OVERFLOW,
    output logic              ERR_IDX
);

    localparam logic [IDX_W-1:0] CP_START = IDX_W'(N_FFT - CP_LEN);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_FFT - 1);

    logic [IDX_W-1:0]  wr_cnt;
    logic              wr_bank;
    logic              dropping;
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              rel_bank;
    logic              drop_now;
    logic              idx_bad;
    logic              len_bad;
    logic              wr_done;
    logic              pop;
    logic              release_bank;

    rd_state_t         state, state_n;
    logic [IDX_W-1:0]  rd_cnt, rd_cnt_n;
    logic              rd_bank, rd_bank_n;
    logic [IDX_W-1:0]  iss_addr;
    logic              issue, iss_first, iss_last;
    logic              can_issue;
    logic [1:0]        in_flight;

    logic [DATA_W-1:0] ram_rd_data;
    logic              p_valid, p_first, p_last;
    logic [DATA_W-1:0] sk_data;
    logic              sk_valid, sk_first, sk_last;

`ifdef CP_INSERT_IDX_CHECK_EN
    assign idx_bad = (S_DATA_IDX_IN != wr_cnt);

    // index mismatch pulse; the frame restart itself is handled by the write counter
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            ERR_IDX <= 1'b0;
        end else begin
            ERR_IDX <= S_DATA_VALID && !drop_now && idx_bad;
        end
    end
`else
    logic unused_idx;
    assign unused_idx = ^S_DATA_IDX_IN;
    assign idx_bad    = 1'b0;
    assign ERR_IDX    = 1'b0;
`endif

    // write-side decode: overflow drop, framing errors and bank completion
    always_comb begin
        drop_now = S_DATA_VALID && (dropping || (wr_cnt == '0 && full[wr_bank]));
        len_bad  = (S_DATA_LAST != (wr_cnt == IDX_MAX));
        wr_done  = S_DATA_VALID && !drop_now && !idx_bad && !len_bad && S_DATA_LAST;
        full_set = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
        pop          = M_DATA_VALID && M_DATA_READY;
        release_bank = pop && M_DATA_LAST;
        full_clr     = release_bank ? (rel_bank ? 2'b10 : 2'b01) : 2'b00;
    end

    // write counter, bank select and drop tracking; a dropped frame raises OVERFLOW only on its first sample
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            dropping <= 1'b0;
            ERR_LEN  <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            ERR_LEN  <= 1'b0;
            OVERFLOW <= 1'b0;
            if (S_DATA_VALID) begin
                if (drop_now) begin
                    OVERFLOW <= !dropping;
                    if (S_DATA_LAST || wr_cnt == IDX_MAX) begin
                        dropping <= 1'b0;
                        wr_cnt   <= '0;
                    end else begin
                        dropping <= 1'b1;
                        wr_cnt   <= wr_cnt + 1'b1;
                    end
                end else if (idx_bad) begin
                    wr_cnt <= '0;
                end else if (len_bad) begin
                    ERR_LEN <= 1'b1;
                    wr_cnt  <= '0;
                end else if (S_DATA_LAST) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    // full flags: set on frame completion, cleared when the last body sample is accepted downstream
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            full     <= 2'b00;
            rel_bank <= 1'b0;
        end else begin
            full <= (full & ~full_clr) | full_set;
            if (release_bank) begin
                rel_bank <= ~rel_bank;
            end
        end
    end

    cp_ram #(.DATA_W(DATA_W)) u_ram (
        .SYS_CLK (SYS_CLK),
        .wr_en   (S_DATA_VALID && !drop_now),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data (S_DATA_RE_IN),
        .rd_addr ({rd_bank, iss_addr}),
        .rd_data (ram_rd_data)
    );

    // at most two samples live between RAM stage, skid and output, so the skid never overflows
    assign in_flight = 2'(p_valid) + 2'(sk_valid) + 2'(M_DATA_VALID) - 2'(pop);
    assign can_issue = (in_flight < 2'd2);

    // read FSM state register
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            rd_cnt  <= rd_cnt_n;
            rd_bank <= rd_bank_n;
        end
    end

    // read issue: IDLE issues the first CP address directly so a new symbol costs no extra cycle
    always_comb begin
        state_n   = state;
        rd_cnt_n  = rd_cnt;
        rd_bank_n = rd_bank;
        issue     = 1'b0;
        iss_first = 1'b0;
        iss_last  = 1'b0;
        iss_addr  = (state == ST_IDLE) ? CP_START : rd_cnt;
        case (state)
            ST_IDLE, ST_CP: begin
                if ((state == ST_CP || full[rd_bank]) && can_issue) begin
                    issue     = 1'b1;
                    iss_first = (iss_addr == CP_START);
                    if (iss_addr == IDX_MAX) begin
                        state_n  = ST_BODY;
                        rd_cnt_n = '0;
                    end else begin
                        state_n  = ST_CP;
                        rd_cnt_n = iss_addr + 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    iss_last = (rd_cnt == IDX_MAX);
                    if (iss_last) begin
                        rd_bank_n = ~rd_bank;
                        rd_cnt_n  = CP_START;
                        state_n   = full[~rd_bank] ? ST_CP : ST_IDLE;
                    end else begin
                        rd_cnt_n = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // RAM-stage tags, one-entry skid and output register; output holds while stalled
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            p_valid      <= 1'b0;
            p_first      <= 1'b0;
            p_last       <= 1'b0;
            sk_valid     <= 1'b0;
            sk_data      <= '0;
            sk_first     <= 1'b0;
            sk_last      <= 1'b0;
            M_DATA_VALID <= 1'b0;
            M_DATA_OUT   <= '0;
            M_DATA_FIRST <= 1'b0;
            M_DATA_LAST  <= 1'b0;
        end else begin
            p_valid <= issue;
            p_first <= iss_first;
            p_last  <= iss_last;
            if (!M_DATA_VALID || pop) begin
                if (sk_valid) begin
                    M_DATA_VALID <= 1'b1;
                    M_DATA_OUT   <= sk_data;
                    M_DATA_FIRST <= sk_first;
                    M_DATA_LAST  <= sk_last;
                    sk_valid     <= p_valid;
                    if (p_valid) begin
                        sk_data  <= ram_rd_data;
                        sk_first <= p_first;
                        sk_last  <= p_last;
                    end
                end else if (p_valid) begin
                    M_DATA_VALID <= 1'b1;
                    M_DATA_OUT   <= ram_rd_data;
                    M_DATA_FIRST <= p_first;
                    M_DATA_LAST  <= p_last;
                end else begin
                    M_DATA_VALID <= 1'b0;
                end
            end else if (p_valid) begin
                sk_valid <= 1'b1;
                sk_data  <= ram_rd_data;
                sk_first <= p_first;
                sk_last  <= p_last;
            end
        end
    end

endmodule

// File: tb/tb_cp_insert.sv
// tb/tb_cp_insert.sv - self-checking bench for cp_insert
module tb_cp_insert;
    import dmt_pkg::*;

    localparam int CP_LEN = 32;
    localparam int DW     = 28;
    localparam int SYM    = CP_LEN + N_FFT;

    logic          SYS_CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] S_DATA_RE_IN;
    logic [6:0]    S_DATA_IDX_IN;
    logic          S_DATA_VALID;
    logic          S_DATA_LAST;
    logic [DW-1:0] M_DATA_OUT;
    logic          M_DATA_VALID;
    logic          M_DATA_READY;
    logic          M_DATA_FIRST;
    logic          M_DATA_LAST;
    logic          ERR_LEN;
    logic          OVERFLOW;
    logic          ERR_IDX;

    cp_insert #(.CP_LEN(CP_LEN), .DATA_W(DW)) dut (
        .SYS_CLK       (SYS_CLK),
        .RST           (RST),
        .S_DATA_RE_IN  (S_DATA_RE_IN),
        .S_DATA_IDX_IN (S_DATA_IDX_IN),
        .S_DATA_VALID  (S_DATA_VALID),
        .S_DATA_LAST   (S_DATA_LAST),
        .M_DATA_OUT    (M_DATA_OUT),
        .M_DATA_VALID  (M_DATA_VALID),
        .M_DATA_READY  (M_DATA_READY),
        .M_DATA_FIRST  (M_DATA_FIRST),
        .M_DATA_LAST   (M_DATA_LAST),
        .ERR_LEN       (ERR_LEN),
        .OVERFLOW      (OVERFLOW),
        .ERR_IDX       (ERR_IDX)
    );

    typedef struct {
        int nsamp;
        int last_pos;
        int rdy;
        bit accept;
        int exp_len;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int n_err_len = 0;
    int n_ovf    = 0;
    int n_err_idx = 0;
    int cyc      = 0;
    int first_hs_cyc = -1;
    int last_hs_cyc  = -1;
    int rdy_mode = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW+2:0] prev_vec;
    bit prev_stall = 1'b0;

    initial forever #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    initial begin
        M_DATA_READY = 1'b1;
        forever begin
            @(posedge SYS_CLK);
            #1;
            case (rdy_mode)
                0:       M_DATA_READY = 1'b1;
                1:       M_DATA_READY = ~M_DATA_READY;
                default: M_DATA_READY = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge SYS_CLK);
            cyc++;
            if (prev_stall)
                chk("stall_hold", {M_DATA_VALID, M_DATA_FIRST, M_DATA_LAST, M_DATA_OUT}, prev_vec);
            prev_stall = M_DATA_VALID && !M_DATA_READY && !RST;
            prev_vec   = {M_DATA_VALID, M_DATA_FIRST, M_DATA_LAST, M_DATA_OUT};
            if (ERR_LEN)  n_err_len++;
            if (OVERFLOW) n_ovf++;
            if (ERR_IDX)  n_err_idx++;
            if (M_DATA_VALID && M_DATA_READY) begin
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                chk("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("out_sample", {M_DATA_FIRST, M_DATA_LAST, M_DATA_OUT}, exp_q.pop_front());
            end
        end
    end

    task automatic send_frame(input int tag, input int nsamp, input int last_pos);
        for (int i = 0; i < nsamp; i++) begin
            S_DATA_VALID  = 1'b1;
            S_DATA_IDX_IN = 7'(i);
            S_DATA_RE_IN  = DW'(tag * 256 + i);
            S_DATA_LAST   = (i == last_pos);
            tick();
        end
        S_DATA_VALID = 1'b0;
        S_DATA_LAST  = 1'b0;
    endtask

    task automatic push_exp(input int tag);
        for (int k = N_FFT - CP_LEN; k < N_FFT; k++)
            exp_q.push_back({k == N_FFT - CP_LEN, 1'b0, DW'(tag * 256 + k)});
        for (int k = 0; k < N_FFT; k++)
            exp_q.push_back({1'b0, k == N_FFT - 1, DW'(tag * 256 + k)});
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() > 0 || M_DATA_VALID) && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (12) tick();
    endtask

    initial begin
        vec_t vecs[7];
        int tag = 1;
        int e0, o0, h0;
        bit found;
        int t;

        vecs[0] = '{128, 127, 0, 1'b1, 0};
        vecs[1] = '{128, 127, 1, 1'b1, 0};
        vecs[2] = '{101, 100, 0, 1'b0, 1};
        vecs[3] = '{128, 127, 0, 1'b1, 0};
        vecs[4] = '{128,  -1, 0, 1'b0, 1};
        vecs[5] = '{  1,   0, 0, 1'b0, 1};
        vecs[6] = '{128, 127, 1, 1'b1, 0};

        RST = 1'b1;
        S_DATA_VALID  = 1'b0;
        S_DATA_LAST   = 1'b0;
        S_DATA_IDX_IN = '0;
        S_DATA_RE_IN  = '0;
        repeat (3) tick();
        chk("reset_outputs", {M_DATA_OUT, M_DATA_VALID, M_DATA_FIRST, M_DATA_LAST, ERR_LEN, OVERFLOW, ERR_IDX}, 0);
        RST = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            rdy_mode = vecs[v].rdy;
            e0 = n_err_len;
            o0 = n_ovf;
            h0 = hs_cnt;
            if (vecs[v].accept) push_exp(tag);
            send_frame(tag, vecs[v].nsamp, vecs[v].last_pos);
            drain();
            chk($sformatf("v%0d_err_len", v), n_err_len - e0, vecs[v].exp_len);
            chk($sformatf("v%0d_overflow", v), n_ovf - o0, 0);
            chk($sformatf("v%0d_handshakes", v), hs_cnt - h0, vecs[v].accept ? SYM : 0);
            tag++;
        end

        rdy_mode = 0;
        push_exp(tag);
        send_frame(tag, 128, 127);
        chk("lat_e0", M_DATA_VALID, 0);
        tick();
        chk("lat_e1", M_DATA_VALID, 0);
        tick();
        chk("lat_e2", {M_DATA_VALID, M_DATA_FIRST}, 2'b11);
        drain();
        tag++;

        h0 = hs_cnt;
        first_hs_cyc = -1;
        push_exp(tag);
        push_exp(tag + 1);
        send_frame(tag, 128, 127);
        send_frame(tag + 1, 128, 127);
        drain();
        chk("b2b_handshakes", hs_cnt - h0, 2 * SYM);
        chk("b2b_span", last_hs_cyc - first_hs_cyc, 2 * SYM - 1);
        tag += 2;

        rdy_mode = 2;
        o0 = n_ovf;
        h0 = hs_cnt;
        e0 = n_err_len;
        push_exp(tag);
        push_exp(tag + 1);
        send_frame(tag, 128, 127);
        send_frame(tag + 1, 128, 127);
        send_frame(tag + 2, 128, 127);
        tick();
        chk("ovf_pulses", n_ovf - o0, 1);
        rdy_mode = 0;
        drain();
        chk("ovf_handshakes", hs_cnt - h0, 2 * SYM);
        chk("ovf_pulses_after", n_ovf - o0, 1);
        chk("ovf_err_len", n_err_len - e0, 0);
        tag += 3;

        rdy_mode = 0;
        push_exp(tag);
        send_frame(tag, 128, 127);
        found = 1'b0;
        t = 0;
        while (!found && t < 500) begin
            if (M_DATA_VALID && !M_DATA_FIRST && M_DATA_OUT[7:0] == 8'd50) found = 1'b1;
            else begin
                tick();
                t++;
            end
        end
        chk("rst_found_body50", found, 1);
        RST = 1'b1;
        tick();
        chk("rst_mid_outputs", {M_DATA_OUT, M_DATA_VALID, M_DATA_FIRST, M_DATA_LAST, ERR_LEN, OVERFLOW, ERR_IDX}, 0);
        exp_q.delete();
        RST = 1'b0;
        tick();
        send_frame(tag + 1, 60, -1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        e0 = n_err_len;
        h0 = hs_cnt;
        push_exp(tag + 2);
        send_frame(tag + 2, 128, 127);
        drain();
        chk("post_rst_err_len", n_err_len - e0, 0);
        chk("post_rst_handshakes", hs_cnt - h0, SYM);

        chk("err_idx_total", n_err_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp_insert.md
CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 SHALL have parameter CP_LEN, default 32, cyclic-prefix length in samples, legal range 1..64.
REQ-002 SHALL have parameter DATA_W, default 28, sample width matching the IFFT real output.
REQ-003 SYS_CLK  input  1  clock; all logic on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 S_DATA_RE_IN  input  DATA_W  real IFFT output sample; the imaginary part is not accepted (DMT).
REQ-006 S_DATA_IDX_IN  input  7  IFFT output index, 0..127.
REQ-007 S_DATA_VALID  input  1  sample qualifier; no backpressure exists, so every valid sample is consumed.
REQ-008 S_DATA_LAST  input  1  marks sample 127 of a symbol.
REQ-009 M_DATA_OUT  output  DATA_W  serialized time-domain sample.
REQ-010 M_DATA_VALID / M_DATA_READY  output / input  1 each  AXI-stream style handshake toward the DAC path.
REQ-011 M_DATA_FIRST  output  1  high with the first CP sample of a symbol.
REQ-012 M_DATA_LAST  output  1  high with body sample 127 of a symbol.
REQ-013 ERR_LEN, OVERFLOW, ERR_IDX  output  1 each  single-cycle error pulses.

Function
REQ-014 SHALL buffer input symbols in two 128-entry banks (ping-pong); the write side fills one bank while the read side drains the other.
REQ-015 The write counter SHALL start at 0 and increment on each valid sample; a bank SHALL be marked full when the counter is 127 and S_DATA_LAST=1.
REQ-016 S_DATA_LAST at counter !=127, or counter 127 with S_DATA_LAST=0: SHALL discard the frame, pulse ERR_LEN, reset the counter to 0, and leave the bank not full.
REQ-017 A valid sample at counter 0 while the target bank is still full: SHALL drop the entire frame (all 128 samples), pulse OVERFLOW once, and write nothing.
REQ-018 Read FSM states SHALL be IDLE, CP and BODY; IDLE->CP when the read bank is full; CP reads addresses 128-CP_LEN..127; BODY reads 0..127.
REQ-019 On the last BODY handshake the FSM SHALL release the bank, toggle the read bank, and go to CP if the new bank is already full, else to IDLE, with no gap between back-to-back symbols.
REQ-020 Full flags SHALL be registered: a bank completed in cycle t is visible to the reader in cycle t+1.
REQ-021 The first M_DATA_VALID SHALL occur 2 cycles after the full flag is set (RAM read plus output register).
REQ-022 While M_DATA_VALID=1 and M_DATA_READY=0, M_DATA_OUT, M_DATA_FIRST and M_DATA_LAST SHALL hold stable; read-ahead SHALL use a one-entry skid so throughput is 1 sample/cycle when READY=1.
REQ-023 Each symbol SHALL emit exactly CP_LEN+128 handshakes.

Reset
REQ-024 On RST all outputs SHALL be 0, the FSM SHALL be IDLE, both banks SHALL be not full, the counter SHALL be 0, and the write and read banks SHALL be 0.
REQ-025 RST mid-symbol SHALL abandon both partial frames; the next symbol SHALL start at counter 0 with no stale output.

Configuration
REQ-026 CP_INSERT_IDX_CHECK_EN defined: a valid sample with S_DATA_IDX_IN != counter SHALL pulse ERR_IDX and discard the frame, handled as in REQ-016 but without ERR_LEN.
REQ-027 CP_INSERT_IDX_CHECK_EN undefined: S_DATA_IDX_IN SHALL be ignored and ERR_IDX SHALL be tied 0.

Structure
REQ-028 The shared package dmt_pkg SHALL hold N_FFT=128, IDX_W=7, DATA_W default, and the read FSM state encoding.
REQ-029 Storage SHALL be the sub-module cp_ram: simple dual-port, 256 x DATA_W, 1-cycle synchronous read, address {bank, idx}.

Verification
REQ-030 Single symbol with value=idx, CP_LEN=32, READY=1 -> output 96..127 then 0..127; FIRST on 96, LAST on body 127; 160 handshakes.
REQ-031 Two back-to-back symbols, READY=1 -> 320 contiguous valid samples with no bubble between symbols.
REQ-032 READY toggling 1/0 every cycle -> sequence identical to REQ-030, with data stable during stalls.
REQ-033 Third symbol arriving while both banks are full -> OVERFLOW pulses once, the first two symbols are output intact, and the third is absent.
REQ-034 LAST at sample 100 -> ERR_LEN pulses, no output, and the following good symbol is output correctly.
REQ-035 RST asserted at body sample 50 -> all outputs are 0 next cycle, and a subsequent symbol is output correctly.
